// File: rtl/plic_claim_sequencer_pkg.sv
// Shared types and constants for the hart-side PLIC claim sequencer.
// Covers the FSM state encodings, bus transfer sizes, the trap cause and the claim-offset helper.
package plic_claim_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BUS_REQ   = 3'd1,
        ST_CLAIM_WR  = 3'd2,
        ST_WAIT_DROP = 3'd3,
        ST_DELIVER   = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        WI_IDLE = 2'd0,
        WI_REQ  = 2'd1,
        WI_WR   = 2'd2
    } wi_state_e;

    typedef enum logic [1:0] {
        MS_BYTE = 2'b00,
        MS_HALF = 2'b01,
        MS_WORD = 2'b10
    } memsize_e;

    localparam logic [31:0] MCAUSE_MEI  = 32'h8000_000B;
    localparam logic [31:0] CLAIM_WDATA = 32'h0100_0000;

    // The claim register sits just past the per-gateway halfword priority array.
    function automatic int unsigned claim_offset(input int unsigned n_gateways);
        return (n_gateways + 1) * 2;
    endfunction

endpackage

// File: rtl/plic_claim_sequencer_bus_write_initiator.sv
// Single-write bus initiator: request/grant, strobe held while the responder is busy,
// and completion on the first edge that samples busy low.
module plic_claim_sequencer_bus_write_initiator
    import plic_claim_sequencer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [31:0]              i_data,
    input  logic [1:0]               i_memsize,
    input  logic                     i_bus_grant,
    input  logic                     i_bus_busy,
    output logic                     o_bus_req,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [31:0]              o_bus_out,
    output logic [1:0]               o_bus_memsize,
    output logic                     o_bus_write_enable,
    output logic                     o_grant_fire,
    output logic                     o_done
);

    wi_state_e                r_state;
    logic                     r_bus_req;
    logic                     r_bus_we;
    logic [ADDRESS_WIDTH-1:0] r_bus_address;
    logic [31:0]              r_bus_out;
    logic [1:0]               r_bus_memsize;

    // Combinational strobes let the owning FSM step on the same edge as this block.
    assign o_grant_fire = (r_state == WI_REQ) && i_bus_grant;
    assign o_done       = (r_state == WI_WR) && !i_bus_busy;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state       <= WI_IDLE;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_address <= '0;
            r_bus_out     <= '0;
            r_bus_memsize <= '0;
        end else begin
            case (r_state)
                WI_IDLE: begin
                    if (i_start) begin
                        r_bus_req <= 1'b1;
                        r_state   <= WI_REQ;
                    end
                end
                WI_REQ: begin
                    if (i_bus_grant) begin
                        r_bus_we      <= 1'b1;
                        r_bus_address <= i_address;
                        r_bus_out     <= i_data;
                        r_bus_memsize <= i_memsize;
                        r_state       <= WI_WR;
                    end
                end
                WI_WR: begin
                    if (!i_bus_busy) begin
                        r_bus_we  <= 1'b0;
                        r_bus_req <= 1'b0;
                        r_state   <= WI_IDLE;
                    end
                end
                default: r_state <= WI_IDLE;
            endcase
        end
    end

    assign o_bus_req          = r_bus_req;
    assign o_bus_address      = r_bus_address;
    assign o_bus_out          = r_bus_out;
    assign o_bus_memsize      = r_bus_memsize;
    assign o_bus_write_enable = r_bus_we;

endmodule

// File: rtl/plic_claim_sequencer.sv
// Hart-side PLIC claim sequencer: claims a notified interrupt with a byte write to the
// claim register, waits for the notify to retire, then hands ID and cause to the trap unit.
module plic_claim_sequencer
    import plic_claim_sequencer_pkg::*;
#(
    parameter int                     N_GATEWAYS    = 17,
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] PLIC_BASE   = '0,
    parameter int                     CLAIM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     interrupt_notify,
    input  logic [7:0]               interrupt_id,
    input  logic                     ext_irq_enable,
    output logic                     bus_req,
    input  logic                     bus_grant,
    output logic [ADDRESS_WIDTH-1:0] bus_address,
    output logic [31:0]              bus_out,
    output logic [1:0]               bus_memsize,
    output logic                     bus_write_enable,
    output logic                     bus_read_enable,
    input  logic                     bus_busy,
    output logic                     irq_valid,
    output logic [7:0]               irq_id,
    output logic [31:0]              irq_cause,
    input  logic                     irq_ack,
    output logic                     claim_retry
);

    localparam int CNT_W = $clog2(CLAIM_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLAIM_TIMEOUT - 1);
    localparam logic [ADDRESS_WIDTH-1:0] CLAIM_ADDR =
        PLIC_BASE + ADDRESS_WIDTH'(claim_offset(N_GATEWAYS));

    seq_state_e   r_state;
    logic [7:0]   r_latched_id;
    logic [CNT_W-1:0] r_cnt;
    logic         r_irq_valid;
    logic [7:0]   r_irq_id;
    logic [31:0]  r_irq_cause;
    logic         r_claim_retry;

    logic w_trigger;
    logic w_timeout;
    logic w_start;
    logic w_grant_fire;
    logic w_done;

    assign w_trigger = interrupt_notify && (interrupt_id != 8'd0) && ext_irq_enable;
    assign w_timeout = (r_state == ST_WAIT_DROP) && interrupt_notify && (r_cnt == CNT_LAST);
    // A retry re-arms the initiator on the same edge the FSM returns to BUS_REQ.
    assign w_start   = ((r_state == ST_IDLE) && w_trigger) || w_timeout;

    plic_claim_sequencer_bus_write_initiator #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_bus_write_initiator (
        .clk                (clk),
        .reset_             (reset_),
        .i_start            (w_start),
        .i_address          (CLAIM_ADDR),
        .i_data             (CLAIM_WDATA),
        .i_memsize          (MS_BYTE),
        .i_bus_grant        (bus_grant),
        .i_bus_busy         (bus_busy),
        .o_bus_req          (bus_req),
        .o_bus_address      (bus_address),
        .o_bus_out          (bus_out),
        .o_bus_memsize      (bus_memsize),
        .o_bus_write_enable (bus_write_enable),
        .o_grant_fire       (w_grant_fire),
        .o_done             (w_done)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state       <= ST_IDLE;
            r_latched_id  <= 8'd0;
            r_cnt         <= '0;
            r_irq_valid   <= 1'b0;
            r_irq_id      <= 8'd0;
            r_irq_cause   <= 32'd0;
            r_claim_retry <= 1'b0;
        end else begin
            r_claim_retry <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_latched_id <= interrupt_id;
                        r_state      <= ST_BUS_REQ;
                    end
                end
                ST_BUS_REQ: begin
                    if (w_grant_fire) begin
                        r_state <= ST_CLAIM_WR;
                    end
                end
                ST_CLAIM_WR: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_DROP;
                    end
                end
                ST_WAIT_DROP: begin
                    if (!interrupt_notify) begin
                        r_irq_valid <= 1'b1;
                        r_irq_id    <= r_latched_id;
                        r_irq_cause <= MCAUSE_MEI;
                        r_state     <= ST_DELIVER;
                    end else if (r_cnt == CNT_LAST) begin
                        r_claim_retry <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_BUS_REQ;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DELIVER: begin
                    // irq_id/irq_cause stay put after the ack until the next delivery.
                    if (irq_ack) begin
                        r_irq_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus_read_enable = 1'b0;
    assign irq_valid       = r_irq_valid;
    assign irq_id          = r_irq_id;
    assign irq_cause       = r_irq_cause;
    assign claim_retry     = r_claim_retry;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Self-checking bench for plic_claim_sequencer: vector table of claim transactions plus
// hand sequences for gating, timeout/retry, reset mid-write and zero-ID notifies.
module tb_plic_claim_sequencer;

    localparam int          TO        = 4;
    localparam logic [31:0] EXP_ADDR  = 32'd36;
    localparam logic [31:0] EXP_DATA  = 32'h0100_0000;
    localparam logic [1:0]  EXP_SIZE  = 2'b00;
    localparam logic [31:0] EXP_CAUSE = 32'h8000_000B;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        interrupt_notify = 1'b0;
    logic [7:0]  interrupt_id = 8'd0;
    logic        ext_irq_enable = 1'b0;
    logic        bus_req;
    logic        bus_grant = 1'b0;
    logic [31:0] bus_address;
    logic [31:0] bus_out;
    logic [1:0]  bus_memsize;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic        bus_busy = 1'b0;
    logic        irq_valid;
    logic [7:0]  irq_id;
    logic [31:0] irq_cause;
    logic        irq_ack = 1'b0;
    logic        claim_retry;

    plic_claim_sequencer #(
        .N_GATEWAYS(17), .ADDRESS_WIDTH(32), .PLIC_BASE(32'h0), .CLAIM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_(reset_),
        .interrupt_notify(interrupt_notify), .interrupt_id(interrupt_id),
        .ext_irq_enable(ext_irq_enable),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_address(bus_address),
        .bus_out(bus_out), .bus_memsize(bus_memsize),
        .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable),
        .bus_busy(bus_busy),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_cause(irq_cause),
        .irq_ack(irq_ack), .claim_retry(claim_retry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } wr_t;

    typedef struct {
        logic [7:0] id;
        int         g;
        int         b;
        int         d;
    } vec_t;

    wr_t        sb_wr[$];
    logic [7:0] sb_irq[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_writes = 0;
    int         cfg_gdelay = 0;
    int         cfg_busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Responder/arbiter model: grant after cfg_gdelay cycles, busy for cfg_busy cycles.
    initial begin
        int g_cnt;
        int b_cnt;
        g_cnt = 0;
        b_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus_req && !bus_write_enable && !bus_grant) begin
                if (g_cnt >= cfg_gdelay) bus_grant = 1'b1;
                else g_cnt++;
            end else begin
                bus_grant = 1'b0;
                g_cnt = 0;
            end
            if (bus_write_enable) begin
                if (b_cnt < cfg_busy) begin
                    bus_busy = 1'b1;
                    b_cnt++;
                end else begin
                    bus_busy = 1'b0;
                end
            end else begin
                bus_busy = 1'b0;
                b_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: pops expected writes and deliveries as they appear.
    initial begin
        logic prev_we;
        logic prev_valid;
        wr_t  w;
        logic [7:0] e;
        prev_we = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_) begin
                if (bus_write_enable && !prev_we) begin
                    n_writes++;
                    if (sb_wr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                    else begin
                        w = sb_wr.pop_front();
                        chk("wr_addr", bus_address, w.addr);
                        chk("wr_data", bus_out, w.data);
                        chk("wr_size", 32'(bus_memsize), 32'(w.size));
                    end
                end
                if (bus_write_enable) begin
                    chk("wr_hold_req", 32'(bus_req), 32'd1);
                    chk("wr_hold_addr", bus_address, EXP_ADDR);
                end
                if (irq_valid && !prev_valid) begin
                    if (sb_irq.size() == 0) chk("unexpected_irq", 32'd1, 32'd0);
                    else begin
                        e = sb_irq.pop_front();
                        chk("irq_id", 32'(irq_id), 32'(e));
                        chk("irq_cause", irq_cause, EXP_CAUSE);
                    end
                end
            end
            prev_we = bus_write_enable;
            prev_valid = irq_valid;
        end
    end

    task automatic push_claim(input logic [7:0] id, input int n_wr);
        wr_t w;
        w = '{EXP_ADDR, EXP_DATA, EXP_SIZE};
        for (int i = 0; i < n_wr; i++) sb_wr.push_back(w);
        sb_irq.push_back(id);
    endtask

    task automatic wait_write_done(output bit ok);
        bit saw;
        saw = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus_write_enable) saw = 1'b1;
            else if (saw) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_irq(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (irq_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_and_check(input logic [7:0] id);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("ack_clears_valid", 32'(irq_valid), 32'd0);
        chk("id_held_after_ack", 32'(irq_id), 32'(id));
        chk("cause_held_after_ack", irq_cause, EXP_CAUSE);
        @(negedge clk);
    endtask

    // One full claim: drive notify, let the responder pace it, drop notify d cycles after the write.
    task automatic run_txn(input logic [7:0] id, input int g, input int b, input int d);
        int lat, dcnt, stall, hold, w0;
        bit saw, got;
        cfg_gdelay = g;
        cfg_busy = b;
        push_claim(id, 1);
        w0 = n_writes;
        interrupt_notify = 1'b1;
        interrupt_id = id;
        ext_irq_enable = 1'b1;
        lat = 0; dcnt = -1; stall = 0; hold = 0; saw = 1'b0; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (bus_req && !bus_write_enable) stall++;
            if (bus_write_enable) begin
                hold++;
                saw = 1'b1;
            end else if (saw && dcnt == -1) dcnt = d;
            if (dcnt == 0) begin
                interrupt_notify = 1'b0;
                dcnt = -2;
            end else if (dcnt > 0) dcnt--;
            if (irq_valid) got = 1'b1;
        end
        chk("deliver_seen", 32'(got), 32'd1);
        chk("latency", lat, 4 + g + b + d);
        chk("grant_wait_cycles", stall, g + 1);
        chk("strobe_hold_cycles", hold, b + 1);
        chk("single_write", n_writes - w0, 1);
        ack_and_check(id);
    endtask

    vec_t vecs[5];

    initial begin
        bit ok;
        int cnt, w0, rc;

        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cnt, w0, rc;
        vecs[0] = '{8'd5,   0, 0, 0};
        vecs[1] = '{8'd9,   2, 0, 0};
        vecs[2] = '{8'd200, 0, 3, 0};
        vecs[3] = '{8'd255, 1, 1, 2};
        vecs[4] = '{8'd1,   6, 5, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_write_enable), 32'd0);
        chk("rst_re", 32'(bus_read_enable), 32'd0);
        chk("rst_irq_valid", 32'(irq_valid), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_irq_cause", irq_cause, 32'd0);
        chk("rst_retry", 32'(claim_retry), 32'd0);
        chk("rst_addr", bus_address, 32'd0);
        reset_ = 1'b1;
        @(negedge clk);

        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("stray_ack_no_valid", 32'(irq_valid), 32'd0);

        foreach (vecs[i]) run_txn(vecs[i].id, vecs[i].g, vecs[i].b, vecs[i].d);

        // Gating by ext_irq_enable
        cfg_gdelay = 0; cfg_busy = 0;
        interrupt_notify = 1'b1; interrupt_id = 8'd3; ext_irq_enable = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_req || bus_write_enable) cnt++;
        end
        chk("gated_no_bus", cnt, 0);
        run_txn(8'd3, 0, 0, 0);

        // Timeout and re-issued claim
        cfg_gdelay = 0; cfg_busy = 0;
        push_claim(8'h42, 2);
        w0 = n_writes;
        interrupt_notify = 1'b1; interrupt_id = 8'h42; ext_irq_enable = 1'b1;
        wait_write_done(ok);
        chk("to_first_write_done", 32'(ok), 32'd1);
        rc = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            rc++;
            if (claim_retry) break;
        end
        chk("retry_after_cycles", rc, TO);
        @(negedge clk);
        chk("retry_is_pulse", 32'(claim_retry), 32'd0);
        wait_write_done(ok);
        chk("to_second_write_done", 32'(ok), 32'd1);
        interrupt_notify = 1'b0;
        wait_irq(ok);
        chk("to_deliver_seen", 32'(ok), 32'd1);
        chk("to_write_count", n_writes - w0, 2);
        ack_and_check(8'h42);

        // Asynchronous reset in the middle of the claim write
        cfg_gdelay = 0; cfg_busy = 20;
        push_claim(8'h11, 1);
        interrupt_notify = 1'b1; interrupt_id = 8'h11; ext_irq_enable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus_write_enable) break;
        end
        chk("rst_mid_reached_write", 32'(bus_write_enable), 32'd1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("rst_mid_we", 32'(bus_write_enable), 32'd0);
        chk("rst_mid_req", 32'(bus_req), 32'd0);
        chk("rst_mid_valid", 32'(irq_valid), 32'd0);
        chk("rst_mid_state", int'(dut.r_state), 0);
        sb_irq.delete();
        sb_wr.delete();
        @(negedge clk);
        cfg_busy = 0;
        @(negedge clk);
        reset_ = 1'b1;
        run_txn(8'd7, 0, 0, 0);

        // Zero ID while notify is high
        interrupt_notify = 1'b1; interrupt_id = 8'd0; ext_irq_enable = 1'b1;
        w0 = n_writes;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_req || bus_write_enable || irq_valid) cnt++;
        end
        chk("id0_no_activity", cnt, 0);
        chk("id0_no_write", n_writes - w0, 0);
        interrupt_notify = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/plic_claim_sequencer.md
Name: plic_claim_sequencer

Overview:
- Hart-side counterpart of the PLIC.
- Consumes interrupt_notify/interrupt_id and, as a bus initiator, writes the PLIC claim register over the memory-mapped port using the busy handshake.
- Waits for the notification to retire, then delivers the latched ID and cause to the core trap unit with a valid/ack handshake.
- Sits between the PLIC, the memory-bus arbiter and the core's trap logic.

Parameters:
- N_GATEWAYS, 17: gateway count of the attached PLIC (16 external + mtime).
- ADDRESS_WIDTH, 32: bus address width.
- PLIC_BASE, 32'h0000_0000: byte base address of the PLIC window.
- CLAIM_TIMEOUT, 16: cycles to wait for notify to drop before re-issuing the claim write.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_  input  1  asynchronous active-low reset.
- interrupt_notify  input  1  PLIC has an interrupt in progress.
- interrupt_id  input  8  ID of that interrupt; 0 means none.
- ext_irq_enable  input  1  mstatus.MIE & mie.MEIE from the CSR file.
- bus_req  output  1  request to the bus arbiter.
- bus_grant  input  1  arbiter grant.
- bus_address  output  ADDRESS_WIDTH  PLIC byte address.
- bus_out  output  32  write data; the byte lane is bits 31:24.
- bus_memsize  output  2  `BYTE/`HALF/`WORD from the shared defines.
- bus_write_enable  output  1  write strobe.
- bus_read_enable  output  1  tied 0; this block never reads.
- bus_busy  input  1  responder busy; transaction completes when sampled low.
- irq_valid  output  1  trap request to the core.
- irq_id  output  8  claimed ID.
- irq_cause  output  32  mcause value.
- irq_ack  input  1  core accepted the trap.
- claim_retry  output  1  one-cycle pulse each time the claim write is re-issued.

Behaviour:
- Reset (async, active-low): state=IDLE; all outputs 0; latched ID 0; timeout counter 0. Reset mid-transaction drops bus_write_enable and bus_req immediately. Nothing is replayed after reset.
- Claim address: PLIC_BASE + (N_GATEWAYS+1)*2, i.e. 36 for the default. Write is `BYTE with bus_out=32'h0100_0000. The responder clears the claim register on its own when it returns idle, so no clearing write is issued.
- IDLE: when interrupt_notify=1, interrupt_id!=0 and ext_irq_enable=1, latch interrupt_id and go to BUS_REQ.
  - interrupt_id==0 while notify=1: ignore, stay IDLE.
- BUS_REQ: assert bus_req. On the posedge where bus_grant=1, drive address, size and data, assert bus_write_enable, and go to CLAIM_WR.
  - bus_req remains high through CLAIM_WR.
- CLAIM_WR: hold all bus outputs stable. On a posedge with bus_busy=0:
  - deassert bus_write_enable and bus_req on that edge;
  - clear the counter;
  - go to WAIT_DROP.
  - The minimum CLAIM_WR duration is 1 cycle. There is no upper bound, because the responder paces the transaction.
- WAIT_DROP: when interrupt_notify=0, go to DELIVER. Otherwise increment the counter.
  - On reaching CLAIM_TIMEOUT-1: pulse claim_retry, clear the counter, return to BUS_REQ. Retries are unbounded.
- DELIVER:
  - irq_valid=1, irq_id=latched ID, irq_cause=32'h8000_000B.
  - These outputs are held stable until a posedge with irq_ack=1, then clear irq_valid and go to IDLE.
  - irq_id and irq_cause keep their value after ack until the next delivery.
- Once an ID is latched, ext_irq_enable dropping does not abort the sequence; delivery still completes.
- A new notify during BUS_REQ..DELIVER is ignored until IDLE is re-entered.
- irq_ack while irq_valid=0 has no effect.
- A counter of $clog2(CLAIM_TIMEOUT)+1 bits is sufficient; no wrap is possible because the counter is cleared at the limit.
- Handoff latency from ID latch to irq_valid, with immediate grant, a 1-cycle busy drop and immediate notify drop:
  - IDLE→BUS_REQ: 1 cycle.
  - BUS_REQ→CLAIM_WR: 1 cycle.
  - CLAIM_WR→WAIT_DROP: 1 cycle.
  - WAIT_DROP→DELIVER: 1 cycle.
  - Total: 4 cycles.

Decomposition:
- Shared package/defines:
  - state encoding (IDLE=0, BUS_REQ=1, CLAIM_WR=2, WAIT_DROP=3, DELIVER=4);
  - existing `BYTE/`HALF/`WORD;
  - MCAUSE_MEI=32'h8000_000B;
  - claim-offset macro (N+1)*2.
- One natural sub-module, bus_write_initiator: the single-write busy handshake (req/grant, strobe hold, busy-low completion).
- The sequencer FSM instantiates bus_write_initiator.

Test Plan:
- Basic: notify=1, id=5, enable=1, grant immediate, busy low 1 cycle after strobe, notify falls 1 cycle later. Required response:
  - bus_address=36, bus_memsize=`BYTE, bus_out=32'h0100_0000, single write;
  - irq_valid with irq_id=5, irq_cause=32'h8000_000B;
  - ack clears irq_valid next edge.
- Gating: notify=1, id=3, enable=0 for 10 cycles → no bus_req. Raise enable → sequence runs, irq_id=3.
- Timeout: CLAIM_TIMEOUT=4, notify held high after claim → claim_retry pulses after 4 WAIT_DROP cycles and a second write to address 36 is issued. Drop notify → irq_valid, irq_id unchanged.
- Grant stall: grant low 6 cycles → bus_req high and write_enable low throughout; write starts on the grant edge. busy high 5 cycles → outputs stable until busy low.
- Reset mid-CLAIM_WR: reset_=0 asynchronously → bus_write_enable, bus_req and irq_valid are 0 before the next edge, state IDLE. Release with notify=1, id=7 → fresh claim, irq_id=7.
- id=0 with notify=1 → no bus activity for 20 cycles.
